progmem_port_arbiter: RTL and testbench

//  Shares the single-port program memory between the pipeline fetch stage (read-only)
//  and the debug loader (read/write). Issues at most one MEMREAD/MEMWRITE command per cycle,

---
 rtl/progmem_port_arbiter_if.sv | 40 ++++
 rtl/progmem_port_arbiter.sv | 92 +++++++++
 tb/tb_progmem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/progmem_port_arbiter_if.sv
// Request/response and memory-side signals shared by the program-memory arbiter.
// The arbiter connects through the slave modport; the requesters and the memory use the master modport.
interface progmem_port_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          F_REQ;
  logic [AW-1:0] F_ADDR;
  logic          F_GNT;
  logic          F_VALID;
  logic [DW-1:0] F_DATA;

  logic          D_REQ;
  logic          D_WE;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic          D_LOCK;
  logic          D_GNT;
  logic          D_VALID;
  logic [DW-1:0] D_RDATA;
  logic          D_ERR;

  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;

  modport slave (
    input  F_REQ, F_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_LOCK, MEM_RDATA,
    output F_GNT, F_VALID, F_DATA, D_GNT, D_VALID, D_RDATA, D_ERR,
           MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA
  );

  modport master (
    output F_REQ, F_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_LOCK, MEM_RDATA,
    input  F_GNT, F_VALID, F_DATA, D_GNT, D_VALID, D_RDATA, D_ERR,
           MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA
  );
endinterface

// File: rtl/progmem_port_arbiter.sv
// Shares the single-port program memory between instruction fetch and the debug loader,
// with round-robin arbitration, a debug burst lock and NOP substitution for bad fetch addresses.
module progmem_port_arbiter #(
  parameter int            DW       = 32,
  parameter int            AW       = 32,
  parameter int            DEPTH    = 32,
  parameter logic [DW-1:0] NOP_WORD = 32'hF800_0000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  progmem_port_arbiter_if.slave bus
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t state, state_nxt;
  logic   last_d, last_d_nxt;    // 1: debug won the most recent grant
  logic   locked_now;
  logic   f_gnt, d_gnt;
  logic   f_in, d_in;
  logic   vld_f_p1, vld_d_p1;    // owner tag of the response in flight
  logic   err_p1, rd_p1;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return addr < AW'(DEPTH);
  endfunction

  // Lock release is seen before arbitration so fetch can win the release cycle.
  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    f_gnt      = 1'b0;
    d_gnt      = 1'b0;
    locked_now = (state == LOCKED) && bus.D_LOCK;
    if (RESET) begin
      if (locked_now) begin
        d_gnt = bus.D_REQ;
      end else if (bus.F_REQ && bus.D_REQ) begin
        f_gnt = last_d;
        d_gnt = !last_d;
      end else begin
        f_gnt = bus.F_REQ;
        d_gnt = bus.D_REQ;
      end
    end
    if (f_gnt) last_d_nxt = 1'b0;
    if (d_gnt) last_d_nxt = 1'b1;
    if (locked_now || (d_gnt && bus.D_LOCK)) state_nxt = LOCKED;
    else                                     state_nxt = ARB;
  end

  always_comb begin
    f_in          = in_range(bus.F_ADDR);
    d_in          = in_range(bus.D_ADDR);
    bus.MEM_READ  = (f_gnt && f_in) || (d_gnt && d_in && !bus.D_WE);
    bus.MEM_WRITE = d_gnt && d_in && bus.D_WE;
    bus.MEM_ADDR  = '0;
    if (d_gnt)      bus.MEM_ADDR = bus.D_ADDR;
    else if (f_gnt) bus.MEM_ADDR = bus.F_ADDR;
    bus.MEM_WDATA = bus.MEM_WRITE ? bus.D_WDATA : '0;
  end

  assign bus.F_GNT = f_gnt;
  assign bus.D_GNT = d_gnt;

  // Stage p0 -> p1: grant cycle to response cycle
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= ARB;
      last_d   <= 1'b1;
      vld_f_p1 <= 1'b0;
      vld_d_p1 <= 1'b0;
      err_p1   <= 1'b0;
      rd_p1    <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_d   <= last_d_nxt;
      vld_f_p1 <= f_gnt;
      vld_d_p1 <= d_gnt;
      err_p1   <= f_gnt ? !f_in : (d_gnt ? !d_in : 1'b0);
      rd_p1    <= d_gnt && !bus.D_WE;
    end
  end

  // Stage p1: route registered memory data to the owner only
  assign bus.F_VALID = vld_f_p1;
  assign bus.F_DATA  = vld_f_p1 ? (err_p1 ? NOP_WORD : bus.MEM_RDATA) : '0;
  assign bus.D_VALID = vld_d_p1;
  assign bus.D_ERR   = vld_d_p1 && err_p1;
  assign bus.D_RDATA = (vld_d_p1 && rd_p1 && !err_p1) ? bus.MEM_RDATA : '0;

endmodule

// File: tb/tb_progmem_port_arbiter.sv
// Bench for progmem_port_arbiter: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a rule-level model of ownership, arbitration and memory contents.
module tb_progmem_port_arbiter;

  localparam int DEPTH = 32;
  localparam logic [31:0] NOP = 32'hF800_0000;

  logic CLK = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_errors = 0;

  progmem_port_arbiter_if #(.DW(32), .AW(32)) pif ();

  progmem_port_arbiter #(.DW(32), .AW(32), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (pif)
  );

  always #5 CLK = ~CLK;

  // Physical memory seen by the DUT (registered read)
  logic [31:0] bmem [DEPTH];
  always @(posedge CLK) begin
    if (pif.MEM_WRITE && pif.MEM_ADDR < DEPTH) bmem[pif.MEM_ADDR[4:0]] <= pif.MEM_WDATA;
    if (pif.MEM_READ)
      pif.MEM_RDATA <= (pif.MEM_ADDR < DEPTH) ? bmem[pif.MEM_ADDR[4:0]] : 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the memory, what each owner sees next cycle, what memory holds
  logic [31:0] model_mem [DEPTH];
  bit          m_locked, m_debug_won_last;
  bit          e_fv, e_dv, e_de;
  logic [31:0] e_fd, e_dd;

  always @(negedge CLK) begin : compare
    bit gf, gd, excl, f_ok, d_ok, x_rd, x_wr;
    logic [31:0] x_addr;
    if (!RESET) begin
      chk("rst_f_gnt", pif.F_GNT, 0);
      chk("rst_d_gnt", pif.D_GNT, 0);
      chk("rst_mem_read", pif.MEM_READ, 0);
      chk("rst_mem_write", pif.MEM_WRITE, 0);
      chk("rst_f_valid", pif.F_VALID, 0);
      chk("rst_f_data", pif.F_DATA, 0);
      chk("rst_d_valid", pif.D_VALID, 0);
      chk("rst_d_err", pif.D_ERR, 0);
      chk("rst_d_rdata", pif.D_RDATA, 0);
      m_locked = 0; m_debug_won_last = 1;
      e_fv = 0; e_dv = 0; e_de = 0; e_fd = 0; e_dd = 0;
    end else begin
      chk("f_valid", pif.F_VALID, e_fv);
      chk("f_data", pif.F_DATA, e_fd);
      chk("d_valid", pif.D_VALID, e_dv);
      chk("d_rdata", pif.D_RDATA, e_dd);
      chk("d_err", pif.D_ERR, e_de);
      excl = m_locked && pif.D_LOCK;
      if (excl) begin
        gf = 0; gd = pif.D_REQ;
      end else if (pif.F_REQ && pif.D_REQ) begin
        gd = !m_debug_won_last; gf = !gd;
      end else begin
        gf = pif.F_REQ; gd = pif.D_REQ;
      end
      chk("f_gnt", pif.F_GNT, gf);
      chk("d_gnt", pif.D_GNT, gd);
      f_ok = pif.F_ADDR < DEPTH;
      d_ok = pif.D_ADDR < DEPTH;
      x_rd = (gf && f_ok) || (gd && d_ok && !pif.D_WE);
      x_wr = gd && d_ok && pif.D_WE;
      x_addr = gd ? pif.D_ADDR : pif.F_ADDR;
      chk("mem_read", pif.MEM_READ, x_rd);
      chk("mem_write", pif.MEM_WRITE, x_wr);
      if (x_rd || x_wr) chk("mem_addr", pif.MEM_ADDR, x_addr);
      if (x_wr) chk("mem_wdata", pif.MEM_WDATA, pif.D_WDATA);
      e_fv = gf;
      e_fd = !gf ? 32'h0 : (f_ok ? model_mem[pif.F_ADDR[4:0]] : NOP);
      e_dv = gd;
      e_de = gd && !d_ok;
      e_dd = (gd && d_ok && !pif.D_WE) ? model_mem[pif.D_ADDR[4:0]] : 32'h0;
      if (x_wr) model_mem[pif.D_ADDR[4:0]] = pif.D_WDATA;
      if (gf) m_debug_won_last = 0;
      if (gd) m_debug_won_last = 1;
      m_locked = excl || (gd && pif.D_LOCK);
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    pif.F_REQ = 0; pif.F_ADDR = 0;
    pif.D_REQ = 0; pif.D_WE = 0; pif.D_ADDR = 0; pif.D_WDATA = 0; pif.D_LOCK = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return 32'($urandom_range(0, DEPTH - 1));
    if (r < 19) return 32'($urandom_range(DEPTH, 63));
    return $urandom();
  endfunction

  initial begin : stim
    bit fg, dg;
    for (int i = 0; i < DEPTH; i++) begin
      bmem[i] = $urandom();
      model_mem[i] = bmem[i];
    end
    bmem[5] = 32'h2001_000F; model_mem[5] = 32'h2001_000F;
    idle();

    // Reset holds grants low even with both requests up
    RESET = 0; pif.F_REQ = 1; pif.D_REQ = 1;
    @(negedge CLK);
    chk("reset_f_gnt", pif.F_GNT, 0);
    chk("reset_d_gnt", pif.D_GNT, 0);
    step(); RESET = 1; idle();

    // Reset during a fetch grant drops the response
    step(); pif.F_REQ = 1; pif.F_ADDR = 5;
    @(negedge CLK);
    chk("midrd_f_gnt", pif.F_GNT, 1);
    #1 RESET = 0; pif.F_REQ = 0;
    @(negedge CLK);
    step(); RESET = 1;
    @(negedge CLK);
    chk("midrd_f_valid", pif.F_VALID, 0);
    chk("midrd_f_data", pif.F_DATA, 0);
    chk("midrd_d_valid", pif.D_VALID, 0);

    // Contention: alternate F,D,F,D starting with fetch
    step(); pif.F_REQ = 1; pif.F_ADDR = 1; pif.D_REQ = 1; pif.D_ADDR = 2;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("cont_f_gnt", pif.F_GNT, (k % 2) == 0);
      chk("cont_d_gnt", pif.D_GNT, (k % 2) == 1);
      if (k > 0) chk("cont_f_valid", pif.F_VALID, (k % 2) == 1);
      if (k > 0) chk("cont_d_valid", pif.D_VALID, (k % 2) == 0);
      step();
    end
    idle();
    @(negedge CLK);
    chk("cont_last_d_valid", pif.D_VALID, 1);
    chk("cont_last_f_valid", pif.F_VALID, 0);

    // Solo fetch of address 5
    step(); pif.F_REQ = 1; pif.F_ADDR = 5;
    @(negedge CLK);
    chk("solo_f_gnt", pif.F_GNT, 1);
    chk("solo_mem_read", pif.MEM_READ, 1);
    chk("solo_mem_addr", pif.MEM_ADDR, 5);
    step(); pif.F_REQ = 0;
    @(negedge CLK);
    chk("solo_f_valid", pif.F_VALID, 1);
    chk("solo_f_data", pif.F_DATA, 32'h2001_000F);
    chk("solo_d_valid", pif.D_VALID, 0);

    // Debug lock burst writes 0..3 while fetch waits
    step();
    pif.D_LOCK = 1; pif.D_REQ = 1; pif.D_WE = 1; pif.D_ADDR = 0; pif.D_WDATA = 32'hA0;
    pif.F_REQ = 1; pif.F_ADDR = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("lock_f_gnt", pif.F_GNT, 0);
      chk("lock_d_gnt", pif.D_GNT, 1);
      chk("lock_mem_write", pif.MEM_WRITE, 1);
      step();
      if (i < 3) begin
        pif.D_ADDR = 32'(i + 1); pif.D_WDATA = 32'hA0 + 32'(i + 1);
      end else begin
        pif.D_LOCK = 0; pif.D_REQ = 0; pif.D_WE = 0;
      end
    end
    @(negedge CLK);
    chk("unlock_f_gnt", pif.F_GNT, 1);
    step(); pif.F_REQ = 0;
    @(negedge CLK);
    chk("unlock_f_valid", pif.F_VALID, 1);
    chk("unlock_f_data", pif.F_DATA, 32'hA0);

    // Out-of-range debug write and fetch
    step(); pif.D_REQ = 1; pif.D_WE = 1; pif.D_ADDR = 32; pif.D_WDATA = 32'h5555_5555;
    @(negedge CLK);
    chk("oor_d_gnt", pif.D_GNT, 1);
    chk("oor_mem_write", pif.MEM_WRITE, 0);
    step(); idle(); pif.F_REQ = 1; pif.F_ADDR = 40;
    @(negedge CLK);
    chk("oor_d_valid", pif.D_VALID, 1);
    chk("oor_d_err", pif.D_ERR, 1);
    chk("oor_d_rdata", pif.D_RDATA, 0);
    chk("oor_f_gnt", pif.F_GNT, 1);
    chk("oor_mem_read", pif.MEM_READ, 0);
    step(); pif.F_REQ = 0;
    @(negedge CLK);
    chk("oor_f_valid", pif.F_VALID, 1);
    chk("oor_f_data", pif.F_DATA, 32'hF800_0000);

    // Read after write through memory
    step(); pif.D_REQ = 1; pif.D_WE = 1; pif.D_ADDR = 7; pif.D_WDATA = 32'h1234_5678;
    step(); idle(); pif.F_REQ = 1; pif.F_ADDR = 7;
    @(negedge CLK);
    chk("raw_d_err", pif.D_ERR, 0);
    step(); pif.F_REQ = 0;
    @(negedge CLK);
    chk("raw_f_data", pif.F_DATA, 32'h1234_5678);

    // Randomized traffic; requesters hold until granted
    step();
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      fg = pif.F_GNT; dg = pif.D_GNT;
      step();
      if (!pif.F_REQ || fg) begin
        pif.F_REQ = ($urandom_range(0, 3) != 0);
        pif.F_ADDR = rand_addr();
      end
      if (!pif.D_REQ || dg) begin
        pif.D_REQ = ($urandom_range(0, 2) == 0);
        pif.D_WE = 1'($urandom_range(0, 1));
        pif.D_ADDR = rand_addr();
        pif.D_WDATA = $urandom();
      end
      if ($urandom_range(0, 15) == 0) pif.D_LOCK = !pif.D_LOCK;
      if (c == 1500) begin
        RESET = 0;
        @(negedge CLK);
        step(); RESET = 1;
      end
    end

    step(); idle();
    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
